gpu_prim_setup: RTL and testbench

- First stage of the GPU path, directly downstream of the writeback stage.
- Captures each completed primitive record (GSR value plus three vertex registers) in a small FIFO.
- Computes the screen-space bounding box of each primitive and discards degenerate primitives.
- Hands surviving primitives to the rasterizer over a valid/ready handshake, and drives the stall signal back to writeback.

---
 rtl/gpu_prim_setup.sv | 169 ++++++++++++++++
 tb/tb_gpu_prim_setup.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_prim_setup.sv
// Primitive setup stage: queues writeback primitive records in a small FIFO,
// computes each head's screen-space bounding box, drops degenerate primitives
// and presents survivors to the rasterizer through a one-entry output register.
module gpu_prim_setup #(
  parameter int GSR_W    = 16,
  parameter int VERTEX_W = 30,
  parameter int DEPTH    = 4,
  parameter int CNT_W    = 16
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET_N,
  input  logic                I_LOCK,
  input  logic [GSR_W-1:0]    I_GSRValue,
  input  logic [VERTEX_W-1:0] I_VertexV1,
  input  logic [VERTEX_W-1:0] I_VertexV2,
  input  logic [VERTEX_W-1:0] I_VertexV3,
  input  logic                I_GSRValue_Valid,
  output logic                O_GPUStallSignal,
  output logic                O_Overflow,
  output logic                O_PrimValid,
  input  logic                I_RastReady,
  output logic [GSR_W-1:0]    O_PrimGSR,
  output logic [VERTEX_W-1:0] O_PrimV1,
  output logic [VERTEX_W-1:0] O_PrimV2,
  output logic [VERTEX_W-1:0] O_PrimV3,
  output logic [9:0]          O_BBoxXMin,
  output logic [9:0]          O_BBoxXMax,
  output logic [9:0]          O_BBoxYMin,
  output logic [9:0]          O_BBoxYMax,
  output logic [CNT_W-1:0]    O_DropCount
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FC_W  = $clog2(DEPTH + 1);
  localparam int REC_W = GSR_W + 3 * VERTEX_W;

  logic [REC_W-1:0]    mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W-1:0]    rd_ptr;
  logic [FC_W-1:0]     count;

  logic                fifo_empty;
  logic                fifo_full;
  logic                push;
  logic                pop;
  logic                slot_free;

  logic [REC_W-1:0]    head_rec;
  logic [GSR_W-1:0]    head_gsr;
  logic [VERTEX_W-1:0] head_v1;
  logic [VERTEX_W-1:0] head_v2;
  logic [VERTEX_W-1:0] head_v3;
  logic [9:0]          bb_xmin;
  logic [9:0]          bb_xmax;
  logic [9:0]          bb_ymin;
  logic [9:0]          bb_ymax;
  logic                head_degenerate;

  function automatic logic [9:0] min3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic [9:0] max3(input logic [9:0] a, input logic [9:0] b,
                                      input logic [9:0] c);
    logic [9:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FC_W'(DEPTH));
  assign slot_free  = !O_PrimValid || I_RastReady;

  // A push only uses a slot that is free before this edge; a same-cycle pop
  // does not make room for it.
  assign push = I_LOCK && I_GSRValue_Valid && !fifo_full;
  assign pop  = I_LOCK && !fifo_empty && slot_free;

  // One slot of slack covers writeback's one-cycle reaction to the stall.
  assign O_GPUStallSignal = (count >= FC_W'(DEPTH - 1));

  assign head_rec = mem[rd_ptr];
  assign head_gsr = head_rec[REC_W-1 -: GSR_W];
  assign head_v1  = head_rec[3*VERTEX_W-1 -: VERTEX_W];
  assign head_v2  = head_rec[2*VERTEX_W-1 -: VERTEX_W];
  assign head_v3  = head_rec[VERTEX_W-1:0];

  // Bounding box of the FIFO head over the x and y fields; z plays no part.
  always_comb begin
    bb_xmin = min3(head_v1[29:20], head_v2[29:20], head_v3[29:20]);
    bb_xmax = max3(head_v1[29:20], head_v2[29:20], head_v3[29:20]);
    bb_ymin = min3(head_v1[19:10], head_v2[19:10], head_v3[19:10]);
    bb_ymax = max3(head_v1[19:10], head_v2[19:10], head_v3[19:10]);
    head_degenerate = (bb_xmin == bb_xmax) || (bb_ymin == bb_ymax);
  end

  // FIFO storage needs no reset: only slots counted as occupied are ever read.
  always_ff @(posedge I_CLOCK) begin
    if (push) mem[wr_ptr] <= {I_GSRValue, I_VertexV1, I_VertexV2, I_VertexV3};
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      O_Overflow <= 1'b0;
    end else if (!I_LOCK) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      O_Overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + FC_W'(1);
      else if (pop && !push) count <= count - FC_W'(1);
      if (I_GSRValue_Valid && fifo_full) O_Overflow <= 1'b1;
    end
  end

  // Output register: loads surviving heads, holds while stalled, counts drops.
  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      O_PrimValid <= 1'b0;
      O_PrimGSR   <= '0;
      O_PrimV1    <= '0;
      O_PrimV2    <= '0;
      O_PrimV3    <= '0;
      O_BBoxXMin  <= '0;
      O_BBoxXMax  <= '0;
      O_BBoxYMin  <= '0;
      O_BBoxYMax  <= '0;
      O_DropCount <= '0;
    end else if (!I_LOCK) begin
      O_PrimValid <= 1'b0;
      O_PrimGSR   <= '0;
      O_PrimV1    <= '0;
      O_PrimV2    <= '0;
      O_PrimV3    <= '0;
      O_BBoxXMin  <= '0;
      O_BBoxXMax  <= '0;
      O_BBoxYMin  <= '0;
      O_BBoxYMax  <= '0;
      O_DropCount <= '0;
    end else if (slot_free) begin
      if (!fifo_empty && !head_degenerate) begin
        O_PrimValid <= 1'b1;
        O_PrimGSR   <= head_gsr;
        O_PrimV1    <= head_v1;
        O_PrimV2    <= head_v2;
        O_PrimV3    <= head_v3;
        O_BBoxXMin  <= bb_xmin;
        O_BBoxXMax  <= bb_xmax;
        O_BBoxYMin  <= bb_ymin;
        O_BBoxYMax  <= bb_ymax;
      end else begin
        O_PrimValid <= 1'b0;
        if (!fifo_empty && (O_DropCount != {CNT_W{1'b1}}))
          O_DropCount <= O_DropCount + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_gpu_prim_setup.sv
// Self-checking bench for gpu_prim_setup: a queue-based reference model is
// compared against the DUT every cycle, plus directed literal expectations.
module tb_gpu_prim_setup;

  localparam int GSR_W    = 16;
  localparam int VERTEX_W = 30;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 16;

  typedef struct packed {
    logic [15:0] gsr;
    logic [29:0] v1;
    logic [29:0] v2;
    logic [29:0] v3;
  } rec_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                lock = 1'b0;
  logic [GSR_W-1:0]    gsr_in = '0;
  logic [VERTEX_W-1:0] v1_in = '0;
  logic [VERTEX_W-1:0] v2_in = '0;
  logic [VERTEX_W-1:0] v3_in = '0;
  logic                gsr_valid = 1'b0;
  logic                rast_ready = 1'b0;
  logic                stall;
  logic                overflow;
  logic                prim_valid;
  logic [GSR_W-1:0]    prim_gsr;
  logic [VERTEX_W-1:0] prim_v1;
  logic [VERTEX_W-1:0] prim_v2;
  logic [VERTEX_W-1:0] prim_v3;
  logic [9:0]          bb_xmin;
  logic [9:0]          bb_xmax;
  logic [9:0]          bb_ymin;
  logic [9:0]          bb_ymax;
  logic [CNT_W-1:0]    drop_count;

  int checks = 0;
  int failures = 0;

  gpu_prim_setup #(
    .GSR_W(GSR_W), .VERTEX_W(VERTEX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .I_CLOCK(clk),
    .I_RESET_N(rst_n),
    .I_LOCK(lock),
    .I_GSRValue(gsr_in),
    .I_VertexV1(v1_in),
    .I_VertexV2(v2_in),
    .I_VertexV3(v3_in),
    .I_GSRValue_Valid(gsr_valid),
    .O_GPUStallSignal(stall),
    .O_Overflow(overflow),
    .O_PrimValid(prim_valid),
    .I_RastReady(rast_ready),
    .O_PrimGSR(prim_gsr),
    .O_PrimV1(prim_v1),
    .O_PrimV2(prim_v2),
    .O_PrimV3(prim_v3),
    .O_BBoxXMin(bb_xmin),
    .O_BBoxXMax(bb_xmax),
    .O_BBoxYMin(bb_ymin),
    .O_BBoxYMax(bb_ymax),
    .O_DropCount(drop_count)
  );

  always #5 clk = ~clk;

  function automatic logic [29:0] vtx(input int x, input int y, input int z);
    logic [9:0] xb, yb, zb;
    xb = 10'(x);
    yb = 10'(y);
    zb = 10'(z);
    return {xb, yb, zb};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: the FIFO as a queue, the output slot, counters.
  rec_t m_q[$];
  logic m_valid;
  rec_t m_out;
  int   m_xmin, m_xmax, m_ymin, m_ymax;
  int   m_drop;
  logic m_ovf;

  function automatic int min_of(input int a, input int b, input int c);
    int m;
    m = a;
    if (b < m) m = b;
    if (c < m) m = c;
    return m;
  endfunction

  function automatic int max_of(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_valid = 1'b0;
    m_out = '0;
    m_xmin = 0; m_xmax = 0; m_ymin = 0; m_ymax = 0;
    m_drop = 0;
    m_ovf = 1'b0;
  endtask

  // Model advances on each clock edge from the inputs presented before it.
  always @(posedge clk or negedge rst_n) begin
    int   n0;
    bit   slot;
    rec_t h;
    int   xa, xb2, ya, yb2;
    if (!rst_n || !lock) begin
      model_clear();
    end else begin
      n0 = m_q.size();
      slot = !m_valid || rast_ready;
      if (gsr_valid && n0 == DEPTH) m_ovf = 1'b1;
      if (slot && n0 > 0) begin
        h = m_q.pop_front();
        xa  = min_of(int'(h.v1[29:20]), int'(h.v2[29:20]), int'(h.v3[29:20]));
        xb2 = max_of(int'(h.v1[29:20]), int'(h.v2[29:20]), int'(h.v3[29:20]));
        ya  = min_of(int'(h.v1[19:10]), int'(h.v2[19:10]), int'(h.v3[19:10]));
        yb2 = max_of(int'(h.v1[19:10]), int'(h.v2[19:10]), int'(h.v3[19:10]));
        if (xa == xb2 || ya == yb2) begin
          m_valid = 1'b0;
          if (m_drop < 65535) m_drop++;
        end else begin
          m_valid = 1'b1;
          m_out = h;
          m_xmin = xa; m_xmax = xb2; m_ymin = ya; m_ymax = yb2;
        end
      end else if (slot) begin
        m_valid = 1'b0;
      end
      if (gsr_valid && n0 < DEPTH) m_q.push_back('{gsr_in, v1_in, v2_in, v3_in});
    end
  end

  // Every cycle: compare DUT to the model, and log primitives being accepted.
  logic [15:0] accepted[$];
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("model_valid", 32'(prim_valid), 32'(m_valid));
      checkOutput("model_stall", 32'(stall), 32'(m_q.size() >= DEPTH - 1));
      checkOutput("model_overflow", 32'(overflow), 32'(m_ovf));
      checkOutput("model_drop", 32'(drop_count), 32'(m_drop));
      if (m_valid) begin
        checkOutput("model_gsr", 32'(prim_gsr), 32'(m_out.gsr));
        checkOutput("model_v1", 32'(prim_v1), 32'(m_out.v1));
        checkOutput("model_v2", 32'(prim_v2), 32'(m_out.v2));
        checkOutput("model_v3", 32'(prim_v3), 32'(m_out.v3));
        checkOutput("model_xmin", 32'(bb_xmin), 32'(m_xmin));
        checkOutput("model_xmax", 32'(bb_xmax), 32'(m_xmax));
        checkOutput("model_ymin", 32'(bb_ymin), 32'(m_ymin));
        checkOutput("model_ymax", 32'(bb_ymax), 32'(m_ymax));
      end
      if (lock && prim_valid && rast_ready) accepted.push_back(prim_gsr);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic applyStimulus(input logic v, input int gsr, input logic [29:0] a,
                               input logic [29:0] b, input logic [29:0] c,
                               input logic rdy);
    gsr_valid  = v;
    gsr_in     = 16'(gsr);
    v1_in      = a;
    v2_in      = b;
    v3_in      = c;
    rast_ready = rdy;
    step();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 0, '0, '0, '0, rdy);
  endtask

  initial begin
    int pushed;
    logic v;

    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    lock  = 1'b1;
    checkOutput("reset_valid", 32'(prim_valid), 0);
    checkOutput("reset_stall", 32'(stall), 0);
    checkOutput("reset_drop", 32'(drop_count), 0);

    // Mid-run asynchronous reset with one primitive pending and 3 queued.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 16'h20 + i, vtx(i + 1, i + 2, 0), vtx(i + 5, i + 9, 0),
                    vtx(0, 0, 0), 1'b0);
    gsr_valid = 1'b0;
    checkOutput("midrst_stall_before", 32'(stall), 1);
    checkOutput("midrst_valid_before", 32'(prim_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(prim_valid), 0);
    checkOutput("async_stall", 32'(stall), 0);
    checkOutput("async_ovf", 32'(overflow), 0);
    checkOutput("async_gsr", 32'(prim_gsr), 0);
    checkOutput("async_v1", 32'(prim_v1), 0);
    checkOutput("async_bbox", 32'({bb_xmin, bb_xmax, bb_ymin}), 0);
    checkOutput("async_ymax", 32'(bb_ymax), 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1);
      checkOutput("idle_valid", 32'(prim_valid), 0);
      checkOutput("idle_stall", 32'(stall), 0);
    end

    // Single primitive with the rasterizer ready.
    applyStimulus(1'b1, 16'h0003, vtx(10, 20, 7), vtx(50, 5, 1), vtx(30, 90, 2), 1'b1);
    gsr_valid = 1'b0;
    checkOutput("single_valid_early", 32'(prim_valid), 0);
    idle(1, 1'b1);
    checkOutput("single_valid", 32'(prim_valid), 1);
    checkOutput("single_gsr", 32'(prim_gsr), 32'h3);
    checkOutput("single_xmin", 32'(bb_xmin), 10);
    checkOutput("single_xmax", 32'(bb_xmax), 50);
    checkOutput("single_ymin", 32'(bb_ymin), 5);
    checkOutput("single_ymax", 32'(bb_ymax), 90);
    idle(1, 1'b1);
    checkOutput("single_valid_drop", 32'(prim_valid), 0);

    // Backpressure: six pushes while the rasterizer is not ready.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 16'h10 + i, vtx(1 + i, 2, 0), vtx(40, 30 + i, 0),
                    vtx(20, 60, 0), 1'b0);
      if (i >= 1) checkOutput("bp_hold_gsr", 32'(prim_gsr), 32'h10);
      if (i == 2) checkOutput("bp_stall_low", 32'(stall), 0);
      if (i == 3) checkOutput("bp_stall_high", 32'(stall), 1);
      if (i == 4) checkOutput("bp_ovf_low", 32'(overflow), 0);
      if (i == 5) checkOutput("bp_ovf_high", 32'(overflow), 1);
    end
    accepted.delete();
    idle(8, 1'b1);
    checkOutput("bp_drain_count", 32'(accepted.size()), 5);
    for (int i = 0; i < 5 && i < accepted.size(); i++)
      checkOutput("bp_drain_order", 32'(accepted[i]), 32'h10 + i);
    checkOutput("bp_ovf_sticky", 32'(overflow), 1);

    // Flush with an output pending and 2 entries queued.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 16'h30 + i, vtx(3, 4, 0), vtx(8, 9, 0), vtx(5, 1, 0), 1'b0);
    gsr_valid = 1'b0;
    lock = 1'b0;
    step();
    lock = 1'b1;
    checkOutput("flush_valid", 32'(prim_valid), 0);
    checkOutput("flush_stall", 32'(stall), 0);
    checkOutput("flush_drop", 32'(drop_count), 0);
    checkOutput("flush_ovf", 32'(overflow), 0);
    accepted.delete();
    applyStimulus(1'b1, 16'h55, vtx(1, 1, 0), vtx(9, 2, 0), vtx(4, 7, 0), 1'b1);
    idle(4, 1'b1);
    checkOutput("flush_next_count", 32'(accepted.size()), 1);
    if (accepted.size() > 0) checkOutput("flush_next_gsr", 32'(accepted[0]), 32'h55);

    // Degenerate primitive between two good ones.
    accepted.delete();
    applyStimulus(1'b1, 16'h41, vtx(2, 3, 0), vtx(7, 8, 0), vtx(4, 9, 0), 1'b1);
    applyStimulus(1'b1, 16'h42, vtx(100, 1, 0), vtx(100, 50, 0), vtx(100, 9, 0), 1'b1);
    applyStimulus(1'b1, 16'h43, vtx(6, 6, 0), vtx(60, 16, 0), vtx(30, 2, 0), 1'b1);
    idle(4, 1'b1);
    checkOutput("degen_drop", 32'(drop_count), 1);
    checkOutput("degen_count", 32'(accepted.size()), 2);
    if (accepted.size() == 2) begin
      checkOutput("degen_first", 32'(accepted[0]), 32'h41);
      checkOutput("degen_second", 32'(accepted[1]), 32'h43);
    end

    // Wrap and order: ten records, writeback honours the stall, ready toggles.
    accepted.delete();
    pushed = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      v = (pushed < 10) && !stall;
      applyStimulus(v, pushed + 1, vtx(pushed + 1, 3, 0), vtx(pushed + 20, 40, 0),
                    vtx(5, pushed + 50, 0), (cyc % 2) == 0);
      if (v) pushed++;
    end
    idle(2, 1'b1);
    checkOutput("wrap_pushed", 32'(pushed), 10);
    checkOutput("wrap_count", 32'(accepted.size()), 10);
    for (int i = 0; i < 10 && i < accepted.size(); i++)
      checkOutput("wrap_order", 32'(accepted[i]), 32'(i + 1));
    checkOutput("wrap_ovf", 32'(overflow), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
